// File: rtl/dma_write_engine_pkg.sv
// -----------------------------------------------------------------------------
// dma_write_engine_pkg : shared widths, FSM encoding and helpers for the DMA engine
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package dma_write_engine_pkg;

    localparam int c_word_size = 16;
    localparam int c_line_size = 4;
    localparam int c_line_w    = c_word_size * c_line_size;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } dma_state_t;

    // Line addresses wrap modulo 2^16, so FFFC is followed by 0000.
    function automatic logic [15:0] next_line_addr(input logic [15:0] addr);
        return addr + 16'(c_line_size);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_write_engine_hold.sv
// -----------------------------------------------------------------------------
// dma_hold_timer : counts the cycles a line write is held and flags the last one
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module dma_hold_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int c_cnt_w = $clog2(HOLD_CYCLES + 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_cnt_w'(HOLD_CYCLES - 1);
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign last = en && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/dma_write_engine.sv
// -----------------------------------------------------------------------------
// dma_write_engine : bus-mastering DMA that fetches device lines and writes them
// to memory as full-line writes held for the memory settle window. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module dma_write_engine
    import dma_write_engine_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    input  logic [15:0]         cmd_addr,
    input  logic [CNT_W-1:0]    cmd_lines,
    output logic                cmd_ready,
    input  logic                dev_valid,
    input  logic [c_line_w-1:0] dev_data,
    output logic                dev_ready,
    output logic                br,
    input  logic                bg,
    output logic                dma_writeM,
    output logic [15:0]         dma_address,
    output logic [c_line_w-1:0] dma_data,
    output logic                dma_irq
);

    dma_state_t          r_state;
    dma_state_t          w_next;
    logic [15:0]         r_cur_addr;
    logic [CNT_W-1:0]    r_remaining;
    logic [15:0]         r_address;
    logic [c_line_w-1:0] r_buffer;
    logic                w_capture;
    logic                w_hold_en;
    logic                w_last;

    assign w_hold_en = (r_state == S_WRITE);

    dma_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_capture),
        .en      (w_hold_en),
        .last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        br         = 1'b0;
        dev_ready  = 1'b0;
        dma_writeM = 1'b0;
        dma_irq    = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = (cmd_lines == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                br = 1'b1;
                if (bg) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                br = 1'b1;
                if (!bg) begin
                    w_next = S_REQ;
                end else if (dev_valid) begin
                    dev_ready = 1'b1;
                    w_capture = 1'b1;
                    w_next    = S_WRITE;
                end
            end
            S_WRITE: begin
                // The bus stays ours until the line completes; a grant drop is ignored here.
                br         = 1'b1;
                dma_writeM = 1'b1;
                if (w_last) begin
                    w_next = (r_remaining == CNT_W'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                dma_irq = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_address   <= '0;
            r_buffer    <= '0;
        end else begin
            if ((r_state == S_IDLE) && cmd_valid) begin
                r_cur_addr  <= cmd_addr;
                r_remaining <= cmd_lines;
            end
            if (w_capture) begin
                r_address <= r_cur_addr;
                r_buffer  <= dev_data;
            end
            if (w_hold_en && w_last) begin
                r_cur_addr  <= next_line_addr(r_cur_addr);
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    assign dma_address = r_address;
    assign dma_data    = r_buffer;

endmodule

`default_nettype wire

// File: tb/tb_dma_write_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_write_engine : scoreboard bench for the DMA line-write engine
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_dma_write_engine;

    localparam int HOLD   = 5;
    localparam int CNT_W  = 8;
    localparam int BUDGET = 400;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic [15:0]      cmd_addr;
    logic [CNT_W-1:0] cmd_lines;
    logic             cmd_ready;
    logic             dev_valid;
    logic [63:0]      dev_data = '0;
    logic             dev_ready;
    logic             br;
    logic             bg;
    logic             dma_writeM;
    logic [15:0]      dma_address;
    logic [63:0]      dma_data;
    logic             dma_irq;

    wr_t         exp_q[$];
    logic [63:0] dev_q[$];
    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dma_write_engine #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_lines   (cmd_lines),
        .cmd_ready   (cmd_ready),
        .dev_valid   (dev_valid),
        .dev_data    (dev_data),
        .dev_ready   (dev_ready),
        .br          (br),
        .bg          (bg),
        .dma_writeM  (dma_writeM),
        .dma_address (dma_address),
        .dma_data    (dma_data),
        .dma_irq     (dma_irq)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Device model: presents the head of dev_q; a line is consumed by the edge after dev_ready.
    initial begin : device
        forever begin
            @(negedge clk);
            if (dev_ready === 1'b1) begin
                @(posedge clk);
                #1;
                if (dev_q.size() != 0) void'(dev_q.pop_front());
            end
            dev_data = (dev_q.size() != 0) ? dev_q[0] : 64'h0;
        end
    end

    // Write monitor: compares each line write against the scoreboard and records memory.
    initial begin : monitor
        int          run;
        bit          stable;
        logic [15:0] a;
        logic [63:0] d;
        wr_t         e;
        run = 0;
        stable = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                run = 0;
            end else if (dma_writeM === 1'b1) begin
                if (run == 0) begin
                    a = dma_address;
                    d = dma_data;
                    stable = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 64'(a), 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(a), 64'(e.addr));
                        chk("wr_data", d, e.data);
                    end
                end else if ((dma_address !== a) || (dma_data !== d)) begin
                    stable = 1'b0;
                end
                run++;
            end else if (run != 0) begin
                chk("hold_len", 64'(run), 64'(HOLD));
                chk("hold_stable", 64'(stable), 64'd1);
                for (int k = 0; k < 4; k++) begin
                    mem[a + 16'(k)] = d[16*k +: 16];
                end
                run = 0;
            end
        end
    end

    task automatic push_line(input logic [15:0] addr, input logic [63:0] data);
        exp_q.push_back({addr, data});
        dev_q.push_back(data);
    endtask

    task automatic send_cmd(input logic [15:0] addr, input int lines);
        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_lines = CNT_W'(lines);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Counts cycles after the accepting edge until irq; exp_cyc < 0 skips the latency check.
    task automatic wait_irq(input string tag, input int exp_cyc, output int br_cnt);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        br_cnt = 0;
        while (!seen && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (br === 1'b1) br_cnt++;
            if (dma_irq === 1'b1) seen = 1'b1;
        end
        chk({tag, "_irq_seen"}, 64'(seen), 64'd1);
        if (exp_cyc >= 0) chk({tag, "_irq_latency"}, 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        chk({tag, "_irq_pulse"}, 64'(dma_irq), 64'd0);
        chk({tag, "_br_after"}, 64'(br), 64'd0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_write_start(input string tag);
        int cyc;
        cyc = 0;
        while (dma_writeM !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_write_start"}, 64'(dma_writeM), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_br"}, 64'(br), 64'd0);
        chk({tag, "_writeM"}, 64'(dma_writeM), 64'd0);
        chk({tag, "_irq"}, 64'(dma_irq), 64'd0);
        chk({tag, "_dev_ready"}, 64'(dev_ready), 64'd0);
        chk({tag, "_addr"}, 64'(dma_address), 64'd0);
        chk({tag, "_data"}, dma_data, 64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int brc;
        int bad;
        int rises;
        bit prev_w;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_lines = '0;
        dev_valid = 1'b0;
        bg        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // T1/T2: three lines, grant and device always ready.
        bg = 1'b1;
        dev_valid = 1'b1;
        push_line(16'h01F4, 64'h4444_3333_2222_1111);
        push_line(16'h01F8, {$urandom, $urandom});
        push_line(16'h01FC, {$urandom, $urandom});
        send_cmd(16'h01F4, 3);
        wait_irq("t1", 2 + 3 * (1 + HOLD), brc);
        chk("t2_word0", 64'(mem[16'h01F4]), 64'h1111);
        chk("t2_word1", 64'(mem[16'h01F5]), 64'h2222);
        chk("t2_word2", 64'(mem[16'h01F6]), 64'h3333);
        chk("t2_word3", 64'(mem[16'h01F7]), 64'h4444);

        // T4: zero-line command completes without requesting the bus.
        send_cmd(16'h0100, 0);
        wait_irq("t4", 1, brc);
        chk("t4_no_br", 64'(brc), 64'd0);

        // T5: address wraps from FFFC to 0000.
        push_line(16'hFFFC, 64'hA5A5_0000_FFFF_1234);
        push_line(16'h0000, 64'h0F0F_F0F0_5555_AAAA);
        send_cmd(16'hFFFC, 2);
        wait_irq("t5", 2 + 2 * (1 + HOLD), brc);

        // T3: grant withheld, then dropped in WRITE and in FETCH.
        bg = 1'b0;
        push_line(16'h2000, 64'h1000_2000_3000_4000);
        push_line(16'h2004, 64'hDEAD_BEEF_CAFE_F00D);
        push_line(16'h2008, 64'h0123_4567_89AB_CDEF);
        send_cmd(16'h2000, 3);
        brc = 0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (br === 1'b1) brc++;
            if (dma_writeM !== 1'b0 || dev_ready !== 1'b0) bad++;
        end
        chk("t3_br_waiting", 64'(brc), 64'd10);
        chk("t3_idle_bus", 64'(bad), 64'd0);
        bg = 1'b1;
        wait_write_start("t3a");
        bg = 1'b0;
        while (dma_writeM === 1'b1) @(negedge clk);
        bad = 0;
        brc = 0;
        repeat (4) begin
            @(negedge clk);
            if (br === 1'b1) brc++;
            if (dma_writeM !== 1'b0 || dev_ready !== 1'b0) bad++;
        end
        chk("t3_regrant_br", 64'(brc), 64'd4);
        chk("t3_no_fetch_wo_bg", 64'(bad), 64'd0);
        dev_valid = 1'b0;
        bg = 1'b1;
        repeat (3) @(negedge clk);
        bg = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (dma_writeM !== 1'b0 || dev_ready !== 1'b0) bad++;
        end
        chk("t3_fetch_drop", 64'(bad), 64'd0);
        bg = 1'b1;
        dev_valid = 1'b1;
        wait_irq("t3", -1, brc);

        // T6: reset in the third hold cycle of line 2 abandons the transfer.
        push_line(16'h3000, 64'h1111_1111_1111_1111);
        push_line(16'h3004, 64'h2222_2222_2222_2222);
        push_line(16'h3008, 64'h3333_3333_3333_3333);
        send_cmd(16'h3000, 3);
        rises = 0;
        prev_w = 1'b0;
        for (int c = 0; c < BUDGET && rises < 2; c++) begin
            @(negedge clk);
            if (dma_writeM === 1'b1 && !prev_w) rises++;
            prev_w = dma_writeM;
        end
        chk("t6_second_line", 64'(rises), 64'd2);
        repeat (2) @(negedge clk);
        chk("t6_in_hold", 64'(dma_writeM), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        @(negedge clk);
        chk("t6_no_irq", 64'(dma_irq), 64'd0);
        exp_q.delete();
        dev_q.delete();
        reset_n = 1'b1;
        push_line(16'h4000, 64'h9999_8888_7777_6666);
        push_line(16'h4004, 64'h5555_4444_3333_2222);
        send_cmd(16'h4000, 2);
        wait_irq("t6b", 2 + 2 * (1 + HOLD), brc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
